prm_edge_mask_engine: RTL
=========================

# prm_edge_mask_engine

Programmable, multi-channel successor to the fixed-table obstacle-logic edge checkers: each channel holds a loadable sum-of-products (cube list) over an IN_W-bit edge-state vector and reports that channel's edge_mask bit. It evaluates LANES cubes per channel per cycle, with early exit, behind a valid/ready handshake. It sits between the PRM edge-state encoder and the roadmap edge-pruning logic. It replaces one hard-coded checker per obstacle set with a single reconfigurable block.

## Interface
- IN_W, 15: edge-state vector width; bit 0 = A … bit 14 = O.
- N_CH, 4: independent checker channels.
- N_CUBES, 64: cube capacity per channel; power of two.
- LANES, 4: cubes evaluated per channel per scan cycle; divides N_CUBES.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  edge vector offered.
- in_ready  out  1  block can accept a vector.
- in_vec  in  IN_W  edge-state vector.
- out_valid  out  1  mask result available.
- out_ready  in  1  consumer takes result.
- out_mask  out  N_CH  per-channel edge_mask; bit c = channel c.
- cfg_we  in  1  cube write strobe.
- cfg_cnt_we  in  1  cube-count write strobe.
- cfg_ch  in  clog2(N_CH)  target channel.
- cfg_idx  in  clog2(N_CUBES)  cube index.
- cfg_care  in  IN_W  care mask; 1 = literal present.
- cfg_val  in  IN_W  literal polarity; 1 = true, 0 = negated.
- cfg_cnt  in  clog2(N_CUBES)+1  active cube count for cfg_ch, 0..N_CUBES.
- cfg_ready  out  1  config writes accepted; high only in IDLE.

## Operation
- Cube match: ((in_vec ^ val) & care) == 0. A cube with care = 0 matches every vector.
- Channel c hits if any cube with index < cnt[c] matches. cnt[c] = 0 means the channel never hits.
- Cube storage is a flop array and is not reset. cnt[] resets to 0.
- States:
  - IDLE: in_ready = 1, cfg_ready = 1.
  - SCAN: scan pointer k = 0, LANES, 2·LANES, …
  - DONE: out_valid = 1.
- IDLE→SCAN on in_valid & in_ready. This edge captures in_vec, clears hit[], and sets k = 0.
- Each SCAN edge: for every channel c and lane j, if k+j < cnt[c] and cube[c][k+j] matches, set hit[c]. Then advance k by LANES.
- SCAN→DONE on the edge where either condition holds:
  - k+LANES ≥ max(cnt[]);
  - every channel with cnt > 0 is hit after the update.
- SCAN always lasts at least one cycle, including when every cnt is 0.
- DONE: out_mask = hit[], held stable while out_ready = 0. DONE→IDLE on out_ready.
- Config writes:
  - Performed only when cfg_ready = 1. Ignored in SCAN or DONE; no queueing.
  - cfg_we and cfg_cnt_we in the same cycle: both are performed.
  - cfg_cnt > N_CUBES saturates to N_CUBES.
  - Writes on the same edge as an input accept take effect before the first scan cycle, so the scan uses the new contents.
- Reset values: in_ready = 0 while rst_n = 0 and 1 after release; out_valid = 0; out_mask = 0; cfg_ready = 0 during reset and 1 after; state = IDLE; cnt[] = 0; hit[] = 0.
- Reset mid-SCAN or mid-DONE aborts the transaction. No result is produced, and cube contents are retained.

## Timing
- Scan cycles S = max(1, ceil(max(cnt)/LANES)), reduced by early exit.
- out_valid rises S edges after the accept edge. Worst case is N_CUBES/LANES edges (16 at defaults).
- No back-to-back overlap: the next accept is no earlier than the edge after the out_valid & out_ready edge. Throughput is one vector per S+2 cycles.
- out_mask is registered and changes only on the SCAN→DONE edge.
- in_ready and cfg_ready are decoded from registered state. They have no combinational path from in_valid or out_ready.

## Test plan
- Reset check: with all cnt = 0, send in_vec = 0x7FFF.
  - Required: out_valid after exactly 1 scan edge, out_mask = 0000.
- Reload the chk280 table:
  - Load the 280-series cube list into channel 0, split at 64 cubes across channels 0–3 with OR-merge in the bench.
  - Sweep all 32768 vectors.
  - Required: the OR of out_mask matches the golden truth-table model.
- Early exit:
  - Setup: channel 0 cube 0 has care = 0; cnt[0] = 64; all other cnt = 0.
  - Required: out_valid 1 edge after accept, out_mask = 0001.
- Full scan:
  - Setup: cnt[1] = 64; only cube 63 matches in_vec = 0x1234 (care = 0x7FFF, val = 0x1234).
  - Required: out_valid at 16 edges, out_mask = 0010. With in_vec = 0x1235, out_mask = 0000.
- Backpressure and config lockout:
  - Hold out_ready = 0 for 10 cycles in DONE, and pulse cfg_we during SCAN and DONE.
  - Required: out_mask stable, in_ready = 0, cfg_ready = 0, cube contents unchanged. Verify by rerunning the vector.
- Reset mid-SCAN:
  - Assert rst_n = 0 at scan edge 5 with cnt = 64.
  - Required: out_valid = 0, state IDLE, cnt[] = 0, no stale result after release.

Source files
------------

// File: rtl/prm_edge_mask_engine.sv
// Programmable multi-channel edge-mask checker: each channel ORs a loadable cube list
// over the edge-state vector, scanning LANES cubes per channel per cycle with early exit.

module pem_cube_lane #(
    parameter int IN_W = 15
) (
    input  logic [IN_W-1:0] vec_i,
    input  logic [IN_W-1:0] care_i,
    input  logic [IN_W-1:0] val_i,
    input  logic            en_i,
    output logic            hit_o
);
    assign hit_o = en_i && (((vec_i ^ val_i) & care_i) == '0);
endmodule

module prm_edge_mask_engine #(
    parameter int IN_W    = 15,
    parameter int N_CH    = 4,
    parameter int N_CUBES = 64,
    parameter int LANES   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IN_W-1:0]            in_vec,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N_CH-1:0]            out_mask,
    input  logic                       cfg_we,
    input  logic                       cfg_cnt_we,
    input  logic [$clog2(N_CH)-1:0]    cfg_ch,
    input  logic [$clog2(N_CUBES)-1:0] cfg_idx,
    input  logic [IN_W-1:0]            cfg_care,
    input  logic [IN_W-1:0]            cfg_val,
    input  logic [$clog2(N_CUBES):0]   cfg_cnt,
    output logic                       cfg_ready
);
    localparam int IDX_W = $clog2(N_CUBES);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    typedef struct packed {
        logic [IN_W-1:0] care;
        logic [IN_W-1:0] val;
    } cube_t;

    state_t                        state_q, state_d;
    logic [IN_W-1:0]               vec_q, vec_d;
    logic [N_CH-1:0]               hit_q, hit_d;
    logic [N_CH-1:0]               mask_q, mask_d;
    logic [CNT_W-1:0]              k_q, k_d;
    logic [N_CH-1:0][CNT_W-1:0]    cnt_q, cnt_d;
    cube_t                         cube_q [N_CH][N_CUBES];

    logic [N_CH-1:0][LANES-1:0]    lane_hit;
    logic [N_CH-1:0]               hit_scan;
    logic [CNT_W-1:0]              max_cnt;
    logic                          all_hit;
    logic [CNT_W:0]                k_nxt;
    logic                          scan_done;
    logic [CNT_W-1:0]              cnt_sat;

    // Ready is gated by rst_n so both handshakes read low while reset is held.
    assign in_ready  = rst_n && (state_q == IDLE);
    assign cfg_ready = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_mask  = mask_q;

    assign cnt_sat = (cfg_cnt > CNT_W'(N_CUBES)) ? CNT_W'(N_CUBES) : cfg_cnt;

    // Cube storage has no reset so contents survive an aborted transaction.
    always_ff @(posedge clk) begin
        if (cfg_ready && cfg_we) begin
            cube_q[cfg_ch][cfg_idx] <= '{care: cfg_care, val: cfg_val};
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        for (genvar j = 0; j < LANES; j++) begin : g_lane
            logic [IDX_W-1:0] idx;
            logic             en;
            assign idx = k_q[IDX_W-1:0] + IDX_W'(j);
            assign en  = (k_q + CNT_W'(j)) < cnt_q[c];
            pem_cube_lane #(.IN_W(IN_W)) u_lane (
                .vec_i  (vec_q),
                .care_i (cube_q[c][idx].care),
                .val_i  (cube_q[c][idx].val),
                .en_i   (en),
                .hit_o  (lane_hit[c][j])
            );
        end
        assign hit_scan[c] = hit_q[c] | (|lane_hit[c]);
    end

    always_comb begin
        max_cnt = '0;
        all_hit = 1'b1;
        for (int c = 0; c < N_CH; c++) begin
            if (cnt_q[c] > max_cnt) max_cnt = cnt_q[c];
            if ((cnt_q[c] != '0) && !hit_scan[c]) all_hit = 1'b0;
        end
    end

    assign k_nxt     = {1'b0, k_q} + (CNT_W+1)'(LANES);
    // With every cnt at zero all_hit is vacuously true, so SCAN still takes one cycle.
    assign scan_done = (k_nxt >= {1'b0, max_cnt}) || all_hit;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        hit_d   = hit_q;
        mask_d  = mask_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        if (cfg_ready && cfg_cnt_we) cnt_d[cfg_ch] = cnt_sat;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SCAN;
                    vec_d   = in_vec;
                    hit_d   = '0;
                    k_d     = '0;
                end
            end
            SCAN: begin
                hit_d = hit_scan;
                k_d   = k_nxt[CNT_W-1:0];
                if (scan_done) begin
                    state_d = DONE;
                    mask_d  = hit_scan;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            hit_q   <= '0;
            mask_q  <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            hit_q   <= hit_d;
            mask_q  <= mask_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
